linear_proj_seq_ctrl: RTL and testbench

//  Sequencer for the Q/K/V linear-projection array: NUM_HEADS*3 multwrap_wbram engines sharing one weight-BRAM port.

---
 rtl/linear_proj_pkg.sv | 25 ++
 rtl/linear_proj_seq_ctrl_if.sv | 24 ++
 rtl/linear_proj_rd_delay.sv | 48 ++++
 rtl/linear_proj_seq_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_linear_proj_seq_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/linear_proj_pkg.sv
// Shared types and constants for the Q/K/V linear-projection sequencers.
package linear_proj_pkg;

    localparam int unsigned NUM_PROJ = 3;
    localparam int unsigned PROJ_Q   = 0;
    localparam int unsigned PROJ_K   = 1;
    localparam int unsigned PROJ_V   = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FEED,
        ST_WAIT,
        ST_PRESENT,
        ST_FINISH
    } proj_seq_state_t;

    // Engine numbering is projection-major: proj*NUM_HEADS + head.
    function automatic int unsigned eng_index(input int unsigned proj,
                                              input int unsigned head,
                                              input int unsigned num_heads);
        return proj * num_heads + head;
    endfunction

endpackage

// File: rtl/linear_proj_seq_ctrl_if.sv
// Input-tile and output-column handshakes of the projection sequencer.
interface linear_proj_seq_ctrl_if #(
    parameter int unsigned TILE_W = 256,
    parameter int unsigned COL_W  = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [TILE_W-1:0] in_tile;
    logic              out_valid;
    logic              out_ready;
    logic [COL_W-1:0]  out_col;

    // Token buffer / downstream side.
    modport master (
        output in_valid, in_tile, out_ready,
        input  in_ready, out_valid, out_col
    );

    // Sequencer side.
    modport slave (
        input  in_valid, in_tile, out_ready,
        output in_ready, out_valid, out_col
    );
endinterface

// File: rtl/linear_proj_rd_delay.sv
// Valid+data shift register that lines up input tiles with weight-BRAM read data.
module linear_proj_rd_delay #(
    parameter int unsigned STAGES = 2,
    parameter int unsigned W      = 256
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         any_valid
);
    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] vld_d;
    logic [W-1:0]      dat_q [STAGES];
    logic [W-1:0]      dat_d [STAGES];

    // Advance one stage per cycle; empty slots carry zero data.
    always_comb begin
        vld_d[0] = in_valid;
        dat_d[0] = in_valid ? in_data : '0;
        for (int unsigned i = 1; i < STAGES; i++) begin
            vld_d[i] = vld_q[i-1];
            dat_d[i] = dat_q[i-1];
        end
    end

    // Stage registers, flushed by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int unsigned i = 0; i < STAGES; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int unsigned i = 0; i < STAGES; i++) begin
                dat_q[i] <= dat_d[i];
            end
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign out_data  = dat_q[STAGES-1];
    assign any_valid = |vld_q;

endmodule

// File: rtl/linear_proj_seq_ctrl.sv
// Sequencer for the NUM_HEADS*3 projection engines sharing one weight-BRAM port:
// feeds K_CHUNKS input tiles per output column, waits for every engine's
// acc_done, then hands the finished column index downstream.
module linear_proj_seq_ctrl
    import linear_proj_pkg::*;
#(
    parameter int unsigned NUM_HEADS   = 4,
    parameter int unsigned K_CHUNKS    = 8,
    parameter int unsigned N_COL_TILES = 4,
    parameter int unsigned TILE_W      = 256,
    parameter int unsigned RD_LAT      = 1,
    parameter int unsigned TIMEOUT_CYC = 1023,
    localparam int unsigned NUM_ENG    = NUM_HEADS * NUM_PROJ,
    localparam int unsigned AW         = (K_CHUNKS * N_COL_TILES > 1) ? $clog2(K_CHUNKS * N_COL_TILES) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    linear_proj_seq_ctrl_if.slave      bus,
    output logic                       w_enb,
    output logic [AW-1:0]              w_addrb,
    output logic                       eng_en,
    output logic [TILE_W-1:0]          eng_tile,
    output logic                       acc_rst,
    input  logic [NUM_ENG-1:0]         eng_acc_done,
    output logic                       busy,
    output logic                       done,
    output logic                       err_timeout
);
    localparam int unsigned CW  = $clog2(N_COL_TILES) + 1;
    localparam int unsigned KW  = $clog2(K_CHUNKS) + 1;
    localparam int unsigned WCW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    proj_seq_state_t state_q, state_d;
    logic [CW-1:0]      col_q, col_d;
    logic [KW-1:0]      k_q, k_d;
    logic [NUM_ENG-1:0] bitmap_q, bitmap_d;
    logic [WCW-1:0]     wcnt_q, wcnt_d;
    logic               in_ready_q, in_ready_d;
    logic               w_enb_q, w_enb_d;
    logic [AW-1:0]      w_addrb_q, w_addrb_d;
    logic               acc_rst_q, acc_rst_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               hs;
    logic               dly_any;

    // Next-state and registered-output computation for the whole sequencer.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        k_d         = k_q;
        bitmap_d    = bitmap_q;
        wcnt_d      = wcnt_q;
        in_ready_d  = in_ready_q;
        w_enb_d     = 1'b0;
        w_addrb_d   = w_addrb_q;
        acc_rst_d   = 1'b0;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;
        err_d       = err_q;
        hs          = bus.in_valid & in_ready_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_CLEAR;
                    col_d     = '0;
                    err_d     = 1'b0;
                    acc_rst_d = 1'b1;
                end
            end
            ST_CLEAR: begin
                k_d        = '0;
                bitmap_d   = '0;
                in_ready_d = 1'b1;
                state_d    = ST_FEED;
            end
            ST_FEED: begin
                if (hs) begin
                    w_enb_d   = 1'b1;
                    w_addrb_d = AW'(col_q) * AW'(K_CHUNKS) + AW'(k_q);
                    k_d       = k_q + KW'(1);
                    if (k_q == KW'(K_CHUNKS - 1)) begin
                        in_ready_d = 1'b0;
                        wcnt_d     = '0;
                        state_d    = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // A pulse landing in the completing cycle still counts.
                bitmap_d = bitmap_q | eng_acc_done;
                if (!dly_any && (&bitmap_d)) begin
                    out_valid_d = 1'b1;
                    state_d     = ST_PRESENT;
                end else if (wcnt_q == WCW'(TIMEOUT_CYC)) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    wcnt_d = wcnt_q + WCW'(1);
                end
            end
            ST_PRESENT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    if (col_q == CW'(N_COL_TILES - 1)) begin
                        done_d  = 1'b1;
                        state_d = ST_FINISH;
                    end else begin
                        col_d     = col_q + CW'(1);
                        acc_rst_d = 1'b1;
                        state_d   = ST_CLEAR;
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset aborts any pass in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            col_q       <= '0;
            k_q         <= '0;
            bitmap_q    <= '0;
            wcnt_q      <= '0;
            in_ready_q  <= 1'b0;
            w_enb_q     <= 1'b0;
            w_addrb_q   <= '0;
            acc_rst_q   <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            k_q         <= k_d;
            bitmap_q    <= bitmap_d;
            wcnt_q      <= wcnt_d;
            in_ready_q  <= in_ready_d;
            w_enb_q     <= w_enb_d;
            w_addrb_q   <= w_addrb_d;
            acc_rst_q   <= acc_rst_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // One register stage for the address plus RD_LAT for the BRAM read.
    linear_proj_rd_delay #(
        .STAGES (RD_LAT + 1),
        .W      (TILE_W)
    ) u_rd_delay (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (hs),
        .in_data   (bus.in_tile),
        .out_valid (eng_en),
        .out_data  (eng_tile),
        .any_valid (dly_any)
    );

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_col   = col_q;
    assign w_enb         = w_enb_q;
    assign w_addrb       = w_addrb_q;
    assign acc_rst       = acc_rst_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err_timeout   = err_q;

endmodule

// File: tb/tb_linear_proj_seq_ctrl.sv
// Self-checking bench for linear_proj_seq_ctrl: table of full-pass scenarios
// plus hand-written timeout and mid-pass reset sequences.
`timescale 1ns/1ps
module tb_linear_proj_seq_ctrl;
    import linear_proj_pkg::*;

    localparam int unsigned NUM_HEADS   = 4;
    localparam int unsigned K_CHUNKS    = 8;
    localparam int unsigned N_COL_TILES = 4;
    localparam int unsigned TILE_W      = 256;
    localparam int unsigned RD_LAT      = 1;
    localparam int unsigned NUM_ENG     = NUM_HEADS * NUM_PROJ;
    localparam int unsigned AW          = $clog2(K_CHUNKS * N_COL_TILES);
    localparam int unsigned CW          = $clog2(N_COL_TILES) + 1;
    localparam int unsigned TO_SHORT    = 15;
    localparam int unsigned ENG_SLOW    = eng_index(PROJ_K, 3, NUM_HEADS);
    localparam int unsigned ENG_DEAD    = eng_index(PROJ_V, 3, NUM_HEADS);

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic [NUM_ENG-1:0] acc_done;

    logic              w_enb, eng_en, acc_rst, busy, done, err;
    logic [AW-1:0]     w_addrb;
    logic [TILE_W-1:0] eng_tile;
    logic              w_enb2, eng_en2, acc_rst2, busy2, done2, err2;
    logic [AW-1:0]     w_addrb2;
    logic [TILE_W-1:0] eng_tile2;

    linear_proj_seq_ctrl_if #(.TILE_W(TILE_W), .COL_W(CW)) bus ();
    linear_proj_seq_ctrl_if #(.TILE_W(TILE_W), .COL_W(CW)) bus2 ();

    assign bus2.in_valid  = bus.in_valid;
    assign bus2.in_tile   = bus.in_tile;
    assign bus2.out_ready = bus.out_ready;

    always #5 clk = ~clk;

    linear_proj_seq_ctrl #(
        .NUM_HEADS(NUM_HEADS), .K_CHUNKS(K_CHUNKS), .N_COL_TILES(N_COL_TILES),
        .TILE_W(TILE_W), .RD_LAT(RD_LAT), .TIMEOUT_CYC(1023)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .bus(bus),
        .w_enb(w_enb), .w_addrb(w_addrb), .eng_en(eng_en), .eng_tile(eng_tile),
        .acc_rst(acc_rst), .eng_acc_done(acc_done),
        .busy(busy), .done(done), .err_timeout(err)
    );

    linear_proj_seq_ctrl #(
        .NUM_HEADS(NUM_HEADS), .K_CHUNKS(K_CHUNKS), .N_COL_TILES(N_COL_TILES),
        .TILE_W(TILE_W), .RD_LAT(RD_LAT), .TIMEOUT_CYC(TO_SHORT)
    ) dut_to (
        .clk(clk), .rst(rst), .start(start), .bus(bus2),
        .w_enb(w_enb2), .w_addrb(w_addrb2), .eng_en(eng_en2), .eng_tile(eng_tile2),
        .acc_rst(acc_rst2), .eng_acc_done(acc_done),
        .busy(busy2), .done(done2), .err_timeout(err2)
    );

    typedef struct {
        int toggle;
        int extra_slow;
        int hold;
        int mid_start;
        int exp_addrs;
        int exp_outs;
        int exp_acc_rst;
        int exp_done;
    } vec_t;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    int                addr_log[$];
    int                hs_cyc[$];
    logic [31:0]       hs_tag[$];
    int                en_cyc[$];
    logic [TILE_W-1:0] en_tile[$];
    int                acc_col[$];
    int                acc_cyc[$];
    int                ov_rise[$];
    int                slow_pulse[$];
    int n_done, n_acc_rst, acc_rst_first_accept, en_cnt;
    int cd[NUM_ENG];
    int extra[NUM_ENG];
    logic [NUM_ENG-1:0] resp_mask;
    bit toggle_mode, ov_prev, err2_prev;
    int hold_left, held_cycles, hold_bad;
    logic [CW-1:0] held_col;
    int last_hs2, err2_rise, done2_cyc, busy2_at_rise;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_logs();
        addr_log.delete(); hs_cyc.delete(); hs_tag.delete(); en_cyc.delete(); en_tile.delete();
        acc_col.delete(); acc_cyc.delete(); ov_rise.delete(); slow_pulse.delete();
        n_done = 0; n_acc_rst = 0; acc_rst_first_accept = -1; en_cnt = 0;
        for (int e = 0; e < NUM_ENG; e++) begin cd[e] = -1; extra[e] = 0; end
        resp_mask = '1; toggle_mode = 1'b0; ov_prev = 1'b0; err2_prev = 1'b0;
        hold_left = 0; held_cycles = 0; hold_bad = 0; held_col = '0;
        last_hs2 = -100; err2_rise = -1; done2_cyc = -1; busy2_at_rise = -1;
    endtask

    // One clock: observe outputs of this cycle, then drive inputs for it.
    task automatic cyc();
        @(posedge clk); #1;
        cycle++;
        if (w_enb) addr_log.push_back(int'(w_addrb));
        if (eng_en) begin en_cyc.push_back(cycle); en_tile.push_back(eng_tile); end
        if (acc_rst) n_acc_rst++;
        if (done) n_done++;
        if (bus.out_valid && !ov_prev) ov_rise.push_back(cycle);
        ov_prev = bus.out_valid;
        if (err2 && !err2_prev) begin err2_rise = cycle; busy2_at_rise = int'(busy2); end
        err2_prev = err2;
        if (done2) done2_cyc = cycle;
        // engine model: acc_done 3 cycles after the last eng_en of a column
        acc_done = '0;
        for (int e = 0; e < NUM_ENG; e++) begin
            if (cd[e] == 0) begin
                acc_done[e] = 1'b1;
                if (e == ENG_SLOW) slow_pulse.push_back(cycle);
            end
            if (cd[e] >= 0) cd[e]--;
        end
        if (eng_en) begin
            en_cnt++;
            if (en_cnt % K_CHUNKS == 0)
                for (int e = 0; e < NUM_ENG; e++) if (resp_mask[e]) cd[e] = 2 + extra[e];
        end
        bus.in_valid = toggle_mode ? ~bus.in_valid : 1'b1;
        bus.in_tile  = {8{32'(cycle)}};
        if (bus.in_valid && bus.in_ready) begin hs_cyc.push_back(cycle); hs_tag.push_back(32'(cycle)); end
        if (bus2.in_valid && bus2.in_ready) last_hs2 = cycle;
        if (bus.out_valid && hold_left > 0) begin
            if (held_cycles > 0 && bus.out_col != held_col) hold_bad++;
            if (acc_rst) hold_bad++;
            held_col = bus.out_col;
            held_cycles++;
            hold_left--;
            bus.out_ready = 1'b0;
        end else begin
            bus.out_ready = 1'b1;
        end
        if (bus.out_valid && bus.out_ready) begin
            acc_col.push_back(int'(bus.out_col));
            acc_cyc.push_back(cycle);
            if (acc_col.size() == 1) acc_rst_first_accept = n_acc_rst;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; acc_done = '0;
        bus.in_valid = 1'b0; bus.in_tile = '0; bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        clear_logs();
    endtask

    task automatic run_pass(input vec_t v);
        bit mid_fired = 1'b0;
        clear_logs();
        toggle_mode = (v.toggle != 0);
        extra[ENG_SLOW] = v.extra_slow;
        hold_left = v.hold;
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int n = 0; n < 3000 && n_done == 0; n++) begin
            start = 1'b0;
            if (v.mid_start != 0 && !mid_fired && hs_cyc.size() == 4) begin
                start = 1'b1;
                mid_fired = 1'b1;
            end
            cyc();
        end
        start = 1'b0;
        repeat (3) cyc();
    endtask

    task automatic check_pass(input vec_t v, input string tag);
        int mism;
        int idx;
        chk({tag, "_addr_count"}, addr_log.size(), v.exp_addrs);
        mism = 0; idx = 0;
        for (int c = 0; c < N_COL_TILES; c++)
            for (int k = 0; k < K_CHUNKS; k++) begin
                if (idx < addr_log.size() && addr_log[idx] != c * K_CHUNKS + k) mism++;
                idx++;
            end
        chk({tag, "_addr_order_mismatches"}, mism, 0);
        chk({tag, "_handshakes"}, hs_cyc.size(), v.exp_addrs);
        chk({tag, "_eng_en_count"}, en_cyc.size(), hs_cyc.size());
        mism = 0;
        for (int i = 0; i < hs_cyc.size() && i < en_cyc.size(); i++) begin
            if (en_cyc[i] != hs_cyc[i] + 1 + RD_LAT) mism++;
            if (en_tile[i] !== {8{hs_tag[i]}}) mism++;
        end
        chk({tag, "_eng_align_mismatches"}, mism, 0);
        chk({tag, "_out_count"}, acc_col.size(), v.exp_outs);
        mism = 0;
        for (int i = 0; i < acc_col.size(); i++) if (acc_col[i] != i) mism++;
        chk({tag, "_out_col_mismatches"}, mism, 0);
        chk({tag, "_acc_rst_count"}, n_acc_rst, v.exp_acc_rst);
        chk({tag, "_done_count"}, n_done, v.exp_done);
        chk({tag, "_busy_end"}, busy, 0);
        chk({tag, "_err_end"}, err, 0);
        if (v.extra_slow != 0) begin
            chk({tag, "_slow_pulses"}, slow_pulse.size(), N_COL_TILES);
            for (int i = 0; i < N_COL_TILES && i < slow_pulse.size() && i < ov_rise.size(); i++)
                chk($sformatf("%s_present_after_slow_%0d", tag, i), ov_rise[i], slow_pulse[i] + 1);
        end
        if (v.hold != 0) begin
            chk({tag, "_held_cycles"}, held_cycles, v.hold);
            chk({tag, "_hold_unstable"}, hold_bad, 0);
            if (acc_cyc.size() > 0 && ov_rise.size() > 0)
                chk({tag, "_first_accept_cycle"}, acc_cyc[0], ov_rise[0] + v.hold);
            chk({tag, "_acc_rst_before_accept"}, acc_rst_first_accept, 1);
        end
    endtask

    vec_t vecs[4];

    initial begin
        vecs[0] = '{toggle: 0, extra_slow: 0,  hold: 0,  mid_start: 0, exp_addrs: 32, exp_outs: 4, exp_acc_rst: 4, exp_done: 1};
        vecs[1] = '{toggle: 1, extra_slow: 0,  hold: 0,  mid_start: 1, exp_addrs: 32, exp_outs: 4, exp_acc_rst: 4, exp_done: 1};
        vecs[2] = '{toggle: 0, extra_slow: 20, hold: 0,  mid_start: 0, exp_addrs: 32, exp_outs: 4, exp_acc_rst: 4, exp_done: 1};
        vecs[3] = '{toggle: 0, extra_slow: 0,  hold: 10, mid_start: 1, exp_addrs: 32, exp_outs: 4, exp_acc_rst: 4, exp_done: 1};

        do_reset();
        chk("reset_busy", busy, 0);
        chk("reset_in_ready", bus.in_ready, 0);
        chk("reset_w_enb", w_enb, 0);
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_err", err, 0);

        for (int i = 0; i < 4; i++) begin
            do_reset();
            run_pass(vecs[i]);
            check_pass(vecs[i], $sformatf("v%0d", i));
        end

        // Engine ENG_DEAD never reports: the short-timeout instance must give up.
        do_reset();
        resp_mask[ENG_DEAD] = 1'b0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int n = 0; n < 300 && err2_rise < 0; n++) cyc();
        chk("to_err_cycle", err2_rise, last_hs2 + 1 + TO_SHORT + 1);
        chk("to_done_cycle", done2_cyc, err2_rise);
        chk("to_busy_at_err", busy2_at_rise, 0);
        chk("to_long_instance_no_err", err, 0);
        chk("to_long_instance_busy", busy, 1);
        cyc();
        chk("to_err_sticky", err2, 1);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("to_err_cleared_by_start", err2, 0);
        chk("to_busy_after_restart", busy2, 1);

        // Reset in the middle of FEED with k=3.
        do_reset();
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int n = 0; n < 50 && hs_cyc.size() < 3; n++) cyc();
        cyc();
        rst = 1'b1;
        cyc();
        chk("midrst_w_enb", w_enb, 0);
        chk("midrst_w_addrb", w_addrb, 0);
        chk("midrst_eng_en", eng_en, 0);
        chk("midrst_eng_tile", eng_tile, 0);
        chk("midrst_in_ready", bus.in_ready, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_acc_rst", acc_rst, 0);
        chk("midrst_done", done, 0);
        rst = 1'b0;
        cyc();
        run_pass(vecs[0]);
        chk("midrst_first_addr", (addr_log.size() > 0) ? addr_log[0] : -1, 0);
        check_pass(vecs[0], "after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no summary expected summary");
        $fatal(1);
    end

endmodule
